mig_app_ui_responder_model: RTL and testbench
=============================================

// Module: mig_app_ui_responder_model
// PURPOSE
//  Responder for the Xilinx MIG native application (UI) interface: accepts app_* read/write commands and write data, stores them in an internal array, and returns read data in order with fixed latency.
//  Replaces MIG + DDR3 model in fast simulation of the DDR3 demo system; sits where the MIG IP sits, facing the demo system's UI-side initiator.
// PARAMETERS
//  addr_width_p      28   app_addr width (16-bit DDR3 word units)
//  data_width_p      128  app_wdf_data/app_rd_data width (one BL8 burst)
//  mem_els_p         4096 bursts of backing storage (power of 2)
//  cmd_fifo_els_p    4    command FIFO depth (power of 2, >=2)
//  wdf_fifo_els_p    4    write-data FIFO depth (power of 2, >=2)
//  read_latency_p    4    cycles from read dequeue to app_rd_data_valid (>=1)
//  calib_cycles_p    64   cycles after reset release until calibration done
// PORTS
//  clk_i                 in  1   UI clock; sole clock
//  reset_active_low_i    in  1   synchronous reset, active low
//  app_addr_i            in  28  burst address; bits [2:0] ignored
//  app_cmd_i             in  3   3'b000 write, 3'b001 read, others illegal
//  app_en_i              in  1   command valid
//  app_rdy_o             out 1   command ready
//  app_wdf_data_i        in  128 write data
//  app_wdf_mask_i        in  16  byte mask, 1 = byte NOT written
//  app_wdf_wren_i        in  1   write data valid
//  app_wdf_end_i         in  1   last beat; must equal wren (single-beat bursts)
//  app_wdf_rdy_o         out 1   write data ready
//  app_rd_data_o         out 128 read data
//  app_rd_data_valid_o   out 1   read data valid (no backpressure)
//  app_rd_data_end_o     out 1   = app_rd_data_valid_o
//  init_calib_complete_o out 1   calibration done
//  error_o               out 1   sticky protocol-error flag
// BEHAVIOUR
//  Reset (reset_active_low_i=0 at posedge): all outputs 0; FIFOs, read pipeline, calib counter, error cleared; storage array NOT cleared. Reset mid-operation drops in-flight commands/data/reads silently.
//  Calibration: counter from 0 after reset release; init_calib_complete_o rises calib_cycles_p cycles later and stays 1. While 0, app_rdy_o=app_wdf_rdy_o=0.
//  Command accept: app_en_i & app_rdy_o at posedge enqueues {cmd,addr}. app_rdy_o = calib & !cmd_full. No pass-through: full FIFO stays not-ready even if it dequeues that cycle.
//  Write data accept: app_wdf_wren_i & app_wdf_rdy_o enqueues {data,mask}; app_wdf_rdy_o = calib & !wdf_full. Data may precede or follow its command by any number of cycles; matched strictly in order.
//  Execution (one head command per cycle; entry enqueued in cycle N is head-eligible at N+1):
//   - write: executes and pops only when wdf FIFO non-empty; writes unmasked bytes to mem[addr[3+:lg(mem_els_p)]], pops both FIFOs. Otherwise stalls head (no reordering).
//   - read: pops, reads the array the same cycle (sees all earlier writes), enters a read_latency_p-stage valid/data shift pipeline; app_rd_data_valid_o/end pulse 1 cycle at exit. Reads return in issue order; back-to-back reads give back-to-back valids.
//   - illegal cmd: pops, no effect, sets error_o.
//  Read latency: cmd accepted at edge N -> earliest valid in cycle N+1+read_latency_p.
//  Address: bits above lg(mem_els_p)+3 ignored (wrap-around aliasing).
//  app_wdf_wren_i & !app_wdf_end_i on accept: sets error_o; data still enqueued.
//  app_rd_data_o holds last valid value between valids (0 after reset).
// CONFIGURATION
//  MIG_UI_MODEL_RANDOM_STALL_EN defined: 16-bit Galois LFSR (seed 16'hACE1, taps 16,14,13,11; reset to seed) steps every cycle; app_rdy_o and app_wdf_rdy_o additionally forced 0 when LFSR[1:0]==2'b00 (~25% stall), independently using bits [1:0] and [3:2].
//  Not defined: no LFSR; ready signals depend only on calib and FIFO fullness.
// TESTING
//  1. Hold reset 10 cycles, release -> init_calib_complete_o, app_rdy_o, app_wdf_rdy_o rise exactly 64 cycles later; all outputs 0 before.
//  2. Write addr 28'h40 data 128'h0123..CDEF mask 0, then read 28'h40 -> one valid pulse returning 128'h0123..CDEF, 5 cycles after read accept.
//  3. Write addr 28'h80 mask 16'hFFFE data all-1s over prior all-0s -> readback 128'h...00FF only byte0 set.
//  4. Issue 4 write cmds with no data -> app_rdy_o drops after 4; supply 4 data beats -> writes drain in order, app_rdy_o returns; reads confirm each.
//  5. 8 back-to-back reads of distinct addresses -> 8 consecutive valid cycles, data in issue order; app_cmd 3'b111 -> error_o=1 sticky, no data.
//  6. Reset asserted with 2 reads in pipeline -> no valid after reset; addr 28'h40 data preserved on post-calib readback; with RANDOM_STALL_EN, test 5 still ordered.

Source files
------------

// File: rtl/mig_app_ui_responder_model.sv
// mig_app_ui_responder_model
//   Behavioural stand-in for the MIG native UI plus DDR3 memory. Read/write
//   commands and write data land in two small FIFOs; the head command
//   executes against an internal burst array. Read data comes back in order
//   through a fixed-latency pipeline.
//
// Ports
//   clk_i                 UI clock
//   reset_active_low_i    synchronous reset, active low
//   app_addr_i            burst address (bits [2:0] and high bits ignored)
//   app_cmd_i             3'b000 write, 3'b001 read, anything else illegal
//   app_en_i / app_rdy_o  command handshake
//   app_wdf_*             write data handshake (data, byte mask, wren, end)
//   app_rd_data_*         read return (valid/end pulse, data holds)
//   init_calib_complete_o calibration done
//   error_o               sticky protocol error
//
// Optional feature macro: MIG_UI_MODEL_RANDOM_STALL_EN
//   When defined, a 16-bit Galois LFSR randomly withdraws both ready signals.
module mig_app_ui_responder_model #(
   parameter int addr_width_p   = 28,
   parameter int data_width_p   = 128,
   parameter int mem_els_p      = 4096,
   parameter int cmd_fifo_els_p = 4,
   parameter int wdf_fifo_els_p = 4,
   parameter int read_latency_p = 4,
   parameter int calib_cycles_p = 64
) (
   input  logic                      clk_i,
   input  logic                      reset_active_low_i,
   input  logic [addr_width_p-1:0]   app_addr_i,
   input  logic [2:0]                app_cmd_i,
   input  logic                      app_en_i,
   output logic                      app_rdy_o,
   input  logic [data_width_p-1:0]   app_wdf_data_i,
   input  logic [data_width_p/8-1:0] app_wdf_mask_i,
   input  logic                      app_wdf_wren_i,
   input  logic                      app_wdf_end_i,
   output logic                      app_wdf_rdy_o,
   output logic [data_width_p-1:0]   app_rd_data_o,
   output logic                      app_rd_data_valid_o,
   output logic                      app_rd_data_end_o,
   output logic                      init_calib_complete_o,
   output logic                      error_o
);

   localparam int mask_width_lp = data_width_p / 8;
   localparam int mem_lg_lp     = $clog2(mem_els_p);
   localparam int cmd_lg_lp     = $clog2(cmd_fifo_els_p);
   localparam int wdf_lg_lp     = $clog2(wdf_fifo_els_p);
   localparam int cmd_cnt_w_lp  = cmd_lg_lp + 1;
   localparam int wdf_cnt_w_lp  = wdf_lg_lp + 1;
   localparam int calib_w_lp    = $clog2(calib_cycles_p + 1);

   logic [data_width_p-1:0]  mem_r [mem_els_p];

   logic [2:0]               cmd_op_r  [cmd_fifo_els_p];
   logic [mem_lg_lp-1:0]     cmd_idx_r [cmd_fifo_els_p];
   logic [cmd_lg_lp-1:0]     cmd_wr_ptr_r, cmd_rd_ptr_r;
   logic [cmd_cnt_w_lp-1:0]  cmd_cnt_r;

   logic [data_width_p-1:0]  wdf_data_r [wdf_fifo_els_p];
   logic [mask_width_lp-1:0] wdf_mask_r [wdf_fifo_els_p];
   logic [wdf_lg_lp-1:0]     wdf_wr_ptr_r, wdf_rd_ptr_r;
   logic [wdf_cnt_w_lp-1:0]  wdf_cnt_r;

   logic [calib_w_lp-1:0]    calib_cnt_r;
   logic                     calib_r;
   logic                     error_r;

   logic                     rd_vld_r [read_latency_p];
   logic [data_width_p-1:0]  rd_dat_r [read_latency_p];
   logic                     rd_valid_r;
   logic [data_width_p-1:0]  rd_data_r;

   logic                     cmd_full_s, wdf_full_s;
   logic                     cmd_stall_s, wdf_stall_s;
   logic                     cmd_push_s, wdf_push_s;
   logic                     head_valid_s;
   logic [2:0]               head_op_s;
   logic [mem_lg_lp-1:0]     head_idx_s;
   logic [data_width_p-1:0]  head_wdata_s;
   logic [mask_width_lp-1:0] head_wmask_s;
   logic                     exec_wr_s, exec_rd_s, exec_ill_s;
   logic                     unused_addr_s;

`ifdef MIG_UI_MODEL_RANDOM_STALL_EN
   logic [15:0] lfsr_r;

   // Galois LFSR (taps 16,14,13,11) stepping every cycle to create random stalls.
   always_ff @(posedge clk_i) begin
      if (!reset_active_low_i) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign cmd_stall_s = (lfsr_r[1:0] == 2'b00);
   assign wdf_stall_s = (lfsr_r[3:2] == 2'b00);
`else
   assign cmd_stall_s = 1'b0;
   assign wdf_stall_s = 1'b0;
`endif

   // Only the burst index bits select storage; the rest alias.
   assign unused_addr_s = ^{app_addr_i[2:0], app_addr_i[addr_width_p-1:mem_lg_lp+3]};

   // Fullness is taken from registered counts only, so a dequeue in the same
   // cycle never lets a full FIFO look ready.
   assign cmd_full_s = (cmd_cnt_r == cmd_cnt_w_lp'(cmd_fifo_els_p));
   assign wdf_full_s = (wdf_cnt_r == wdf_cnt_w_lp'(wdf_fifo_els_p));

   assign app_rdy_o     = calib_r & ~cmd_full_s & ~cmd_stall_s;
   assign app_wdf_rdy_o = calib_r & ~wdf_full_s & ~wdf_stall_s;
   assign cmd_push_s    = app_en_i & app_rdy_o;
   assign wdf_push_s    = app_wdf_wren_i & app_wdf_rdy_o;

   assign head_idx_s   = cmd_idx_r[cmd_rd_ptr_r];
   assign head_wdata_s = wdf_data_r[wdf_rd_ptr_r];
   assign head_wmask_s = wdf_mask_r[wdf_rd_ptr_r];

   // Decode the head command; a write without its data stalls the head.
   always_comb begin
      head_valid_s = reset_active_low_i & (cmd_cnt_r != {cmd_cnt_w_lp{1'b0}});
      head_op_s    = cmd_op_r[cmd_rd_ptr_r];
      exec_wr_s    = 1'b0;
      exec_rd_s    = 1'b0;
      exec_ill_s   = 1'b0;
      if (head_valid_s) begin
         case (head_op_s)
            3'b000:  exec_wr_s  = (wdf_cnt_r != {wdf_cnt_w_lp{1'b0}});
            3'b001:  exec_rd_s  = 1'b1;
            default: exec_ill_s = 1'b1;
         endcase
      end else begin
         exec_wr_s = 1'b0;
      end
   end

   // FIFO payload storage; contents need no reset because counts gate them.
   always_ff @(posedge clk_i) begin
      if (cmd_push_s) begin
         cmd_op_r[cmd_wr_ptr_r]  <= app_cmd_i;
         cmd_idx_r[cmd_wr_ptr_r] <= app_addr_i[3 +: mem_lg_lp];
      end
      if (wdf_push_s) begin
         wdf_data_r[wdf_wr_ptr_r] <= app_wdf_data_i;
         wdf_mask_r[wdf_wr_ptr_r] <= app_wdf_mask_i;
      end
   end

   // Backing store: survives reset; masked bytes (mask bit 1) are left alone.
   always_ff @(posedge clk_i) begin
      if (exec_wr_s) begin
         for (int b = 0; b < mask_width_lp; b++) begin
            if (!head_wmask_s[b]) begin
               mem_r[head_idx_s][b*8 +: 8] <= head_wdata_s[b*8 +: 8];
            end
         end
      end
   end

   // FIFO pointers/counts, calibration counter and sticky error flag.
   always_ff @(posedge clk_i) begin
      if (!reset_active_low_i) begin
         cmd_wr_ptr_r <= {cmd_lg_lp{1'b0}};
         cmd_rd_ptr_r <= {cmd_lg_lp{1'b0}};
         cmd_cnt_r    <= {cmd_cnt_w_lp{1'b0}};
         wdf_wr_ptr_r <= {wdf_lg_lp{1'b0}};
         wdf_rd_ptr_r <= {wdf_lg_lp{1'b0}};
         wdf_cnt_r    <= {wdf_cnt_w_lp{1'b0}};
         calib_cnt_r  <= {calib_w_lp{1'b0}};
         calib_r      <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         if (cmd_push_s) cmd_wr_ptr_r <= cmd_wr_ptr_r + cmd_lg_lp'(1);
         if (head_valid_s && (exec_wr_s || exec_rd_s || exec_ill_s)) begin
            cmd_rd_ptr_r <= cmd_rd_ptr_r + cmd_lg_lp'(1);
         end
         cmd_cnt_r <= cmd_cnt_r + cmd_cnt_w_lp'(cmd_push_s)
                    - cmd_cnt_w_lp'(exec_wr_s | exec_rd_s | exec_ill_s);
         if (wdf_push_s) wdf_wr_ptr_r <= wdf_wr_ptr_r + wdf_lg_lp'(1);
         if (exec_wr_s)  wdf_rd_ptr_r <= wdf_rd_ptr_r + wdf_lg_lp'(1);
         wdf_cnt_r <= wdf_cnt_r + wdf_cnt_w_lp'(wdf_push_s) - wdf_cnt_w_lp'(exec_wr_s);
         // calib_r rises on the calib_cycles_p-th edge after reset release
         if (!calib_r) begin
            calib_cnt_r <= calib_cnt_r + calib_w_lp'(1);
            if (calib_cnt_r == calib_w_lp'(calib_cycles_p - 1)) calib_r <= 1'b1;
         end
         error_r <= error_r | exec_ill_s | (wdf_push_s & ~app_wdf_end_i);
      end
   end

   // Read return pipeline: stage 0 captures the array at dequeue, the output
   // register adds the final stage so valid appears read_latency_p edges later.
   always_ff @(posedge clk_i) begin
      rd_dat_r[0] <= mem_r[head_idx_s];
      for (int i = 1; i < read_latency_p; i++) begin
         rd_dat_r[i] <= rd_dat_r[i-1];
      end
      if (!reset_active_low_i) begin
         for (int i = 0; i < read_latency_p; i++) begin
            rd_vld_r[i] <= 1'b0;
         end
         rd_valid_r <= 1'b0;
         rd_data_r  <= {data_width_p{1'b0}};
      end else begin
         rd_vld_r[0] <= exec_rd_s;
         for (int i = 1; i < read_latency_p; i++) begin
            rd_vld_r[i] <= rd_vld_r[i-1];
         end
         rd_valid_r <= rd_vld_r[read_latency_p-1];
         if (rd_vld_r[read_latency_p-1]) rd_data_r <= rd_dat_r[read_latency_p-1];
      end
   end

   assign app_rd_data_o         = rd_data_r;
   assign app_rd_data_valid_o   = rd_valid_r;
   assign app_rd_data_end_o     = rd_valid_r;
   assign init_calib_complete_o = calib_r;
   assign error_o               = error_r;

endmodule

// File: tb/tb_mig_app_ui_responder_model.sv
// Scoreboarded bench for mig_app_ui_responder_model. Drivers push every
// accepted command and data beat into queues; a negedge monitor replays them
// against a burst-indexed reference memory whenever read data is returned.
module tb_mig_app_ui_responder_model;

   localparam int K_WR = 0, K_RD = 1, K_ILL = 2;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en;
   logic         app_rdy;
   logic [127:0] app_wdf_data;
   logic [15:0]  app_wdf_mask;
   logic         app_wdf_wren;
   logic         app_wdf_end;
   logic         app_wdf_rdy;
   logic [127:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         app_rd_data_end;
   logic         init_calib_complete;
   logic         error_flag;

   typedef struct {int kind; logic [27:0] addr; int acc; bit chk;} cmd_t;
   typedef struct {logic [127:0] data; logic [15:0] mask;} wd_t;

   cmd_t         cq[$];
   wd_t          dq[$];
   logic [127:0] mm [int];
   int           tests = 0, fails = 0, cyc = 0;
   int           run = 0, max_run = 0;
   logic [127:0] last_rd = 128'h0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mig_app_ui_responder_model dut (
      .clk_i(clk), .reset_active_low_i(reset_n),
      .app_addr_i(app_addr), .app_cmd_i(app_cmd), .app_en_i(app_en), .app_rdy_o(app_rdy),
      .app_wdf_data_i(app_wdf_data), .app_wdf_mask_i(app_wdf_mask),
      .app_wdf_wren_i(app_wdf_wren), .app_wdf_end_i(app_wdf_end), .app_wdf_rdy_o(app_wdf_rdy),
      .app_rd_data_o(app_rd_data), .app_rd_data_valid_o(app_rd_data_valid),
      .app_rd_data_end_o(app_rd_data_end), .init_calib_complete_o(init_calib_complete),
      .error_o(error_flag));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [27:0] a);
      return int'(a[14:3]);
   endfunction

   // Monitor: on each returned beat, retire queued commands in issue order.
   always @(negedge clk) begin
      bit found;
      cmd_t c;
      wd_t d;
      if (app_rd_data_valid || app_rd_data_end) check("rd_end", app_rd_data_end, app_rd_data_valid);
      if (app_rd_data_valid) begin
         run++;
         if (run > max_run) max_run = run;
         found = 1'b0;
         while (cq.size() > 0 && !found) begin
            c = cq.pop_front();
            if (c.kind == K_WR) begin
               if (dq.size() == 0) begin
                  check("wdata_avail", 128'd0, 128'd1);
               end else begin
                  d = dq.pop_front();
                  if (!mm.exists(idx_of(c.addr))) mm[idx_of(c.addr)] = 128'h0;
                  for (int b = 0; b < 16; b++)
                     if (!d.mask[b]) mm[idx_of(c.addr)][b*8 +: 8] = d.data[b*8 +: 8];
               end
            end else if (c.kind == K_RD) begin
               found = 1'b1;
               check("rd_data", app_rd_data, mm.exists(idx_of(c.addr)) ? mm[idx_of(c.addr)] : 128'h0);
               if (c.chk) check("rd_latency", 128'(cyc), 128'(c.acc + 5));
               last_rd = app_rd_data;
            end
         end
         if (!found) check("unexpected_valid", 128'd1, 128'd0);
      end else begin
         run = 0;
      end
   end

   task automatic send_cmd(input logic [2:0] op, input logic [27:0] a, input bit chk);
      bit acc = 1'b0;
      int n = 0;
      cmd_t e;
      app_en = 1'b1; app_cmd = op; app_addr = a;
      while (!acc && n < 300) begin
         @(negedge clk); acc = app_rdy;
         @(posedge clk); n++;
      end
      #1;
      app_en = 1'b0;
      if (!acc) begin
         check("cmd_accept_timeout", 128'd0, 128'd1);
      end else begin
         e.kind = (op == 3'b000) ? K_WR : (op == 3'b001) ? K_RD : K_ILL;
         e.addr = a; e.acc = cyc; e.chk = chk;
         cq.push_back(e);
      end
   endtask

   task automatic send_data(input logic [127:0] d, input logic [15:0] m, input logic endb);
      bit acc = 1'b0;
      int n = 0;
      wd_t e;
      app_wdf_wren = 1'b1; app_wdf_end = endb; app_wdf_data = d; app_wdf_mask = m;
      while (!acc && n < 300) begin
         @(negedge clk); acc = app_wdf_rdy;
         @(posedge clk); n++;
      end
      #1;
      app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
      if (!acc) begin
         check("wdf_accept_timeout", 128'd0, 128'd1);
      end else begin
         e.data = d; e.mask = m;
         dq.push_back(e);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int pending_reads();
      int n = 0;
      foreach (cq[i]) if (cq[i].kind == K_RD) n++;
      return n;
   endfunction

   task automatic wait_calib();
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = init_calib_complete;
      end
      check("calib_after_reset", 128'(ok), 128'd1);
      wait_cycles(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      bit ok;
      logic [27:0] a;
      reset_n = 1'b0; app_addr = 28'h0; app_cmd = 3'b000; app_en = 1'b0;
      app_wdf_data = 128'h0; app_wdf_mask = 16'h0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;

      // Reset state and calibration timing.
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
                              init_calib_complete, error_flag}, 128'd0);
      check("reset_rd_data", app_rd_data, 128'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("calib_k%0d", k), 128'(init_calib_complete), 128'(k >= 64));
`ifdef MIG_UI_MODEL_RANDOM_STALL_EN
         if (k < 64) check($sformatf("rdy_k%0d", k), {app_rdy, app_wdf_rdy}, 128'd0);
`else
         check($sformatf("rdy_k%0d", k), {app_rdy, app_wdf_rdy}, {2{k >= 64}});
`endif
      end
      wait_cycles(1);

      // Basic write then read, with latency check.
      send_cmd(3'b000, 28'h40, 1'b0);
      send_data(128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000, 1'b1);
      wait_cycles(5);
      send_cmd(3'b001, 28'h40, 1'b1);
      wait_cycles(10);
      check("t2_value", last_rd, 128'h0123456789ABCDEF0123456789ABCDEF);

      // Byte mask: only byte 0 written.
      send_cmd(3'b000, 28'h80, 1'b0);
      send_data(128'h0, 16'h0000, 1'b1);
      send_cmd(3'b000, 28'h80, 1'b0);
      send_data({128{1'b1}}, 16'hFFFE, 1'b1);
      send_cmd(3'b001, 28'h80, 1'b0);
      wait_cycles(12);
      check("t3_mask", last_rd, 128'h000000000000000000000000000000FF);

      // Commands without data fill the command FIFO.
      for (int i = 0; i < 4; i++) send_cmd(3'b000, 28'h100 + 28'(i * 8), 1'b0);
      @(negedge clk);
      check("t4_rdy_full", 128'(app_rdy), 128'd0);
      wait_cycles(1);
      for (int i = 0; i < 4; i++) send_data(rnd128(), 16'h0000, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = app_rdy;
      end
      check("t4_rdy_return", 128'(ok), 128'd1);
      wait_cycles(1);
      for (int i = 0; i < 4; i++) send_cmd(3'b001, 28'h100 + 28'(i * 8), 1'b0);
      wait_cycles(12);

      // Back-to-back reads, then an illegal command.
      for (int i = 0; i < 8; i++) begin
         send_cmd(3'b000, 28'h400 + 28'(i * 8), 1'b0);
         send_data(rnd128(), 16'h0000, 1'b1);
      end
      wait_cycles(10);
      max_run = 0;
      for (int i = 0; i < 8; i++) send_cmd(3'b001, 28'h400 + 28'(i * 8), 1'b0);
      wait_cycles(20);
`ifndef MIG_UI_MODEL_RANDOM_STALL_EN
      check("t5_b2b_run", 128'(max_run), 128'd8);
`endif
      check("t5_err_pre", 128'(error_flag), 128'd0);
      send_cmd(3'b111, 28'h40, 1'b0);
      wait_cycles(3);
      check("t5_err_set", 128'(error_flag), 128'd1);
      wait_cycles(10);
      check("t5_err_sticky", 128'(error_flag), 128'd1);

      // Randomized traffic on a small aliased address set.
      for (int i = 0; i < 8; i++) begin
         send_cmd(3'b000, 28'h200 + 28'(i * 8), 1'b0);
         send_data(rnd128(), 16'h0000, 1'b1);
      end
      for (int n = 0; n < 60; n++) begin
         int r;
         a = 28'($urandom);
         a[14:3] = 12'(64 + $urandom_range(0, 7));
         r = $urandom_range(0, 2);
         if (r == 0) begin
            send_cmd(3'b000, a, 1'b0);
            send_data(rnd128(), 16'($urandom), 1'b1);
         end else if (r == 1) begin
            send_data(rnd128(), 16'($urandom), 1'b1);
            send_cmd(3'b000, a, 1'b0);
         end else begin
            send_cmd(3'b001, a, 1'b0);
         end
      end
      send_cmd(3'b001, 28'h40, 1'b0);
      wait_cycles(40);
      check("rand_drained", 128'(pending_reads()), 128'd0);

      // Reset with reads in flight: nothing returns, storage survives.
      send_cmd(3'b001, 28'h40, 1'b0);
      send_cmd(3'b001, 28'h40, 1'b0);
      reset_n = 1'b0;
      cq.delete();
      dq.delete();
      wait_cycles(3);
      @(negedge clk);
      check("t6_reset_outputs", {app_rd_data_valid, init_calib_complete, error_flag}, 128'd0);
      check("t6_reset_rd_data", app_rd_data, 128'h0);
      wait_cycles(1);
      reset_n = 1'b1;
      wait_calib();
      send_cmd(3'b001, 28'h40, 1'b1);
      wait_cycles(12);
      check("t6_preserved", last_rd, 128'h0123456789ABCDEF0123456789ABCDEF);

      // wren without end flags an error but the beat is still used.
      check("wdf_end_err_pre", 128'(error_flag), 128'd0);
      send_data(128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F, 16'h0000, 1'b0);
      wait_cycles(2);
      check("wdf_end_err_set", 128'(error_flag), 128'd1);
      send_cmd(3'b000, 28'h300, 1'b0);
      send_cmd(3'b001, 28'h300, 1'b0);
      wait_cycles(15);
      check("wdf_end_data", last_rd, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F);
      check("final_drained", 128'(pending_reads()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
